hazard_ctl: RTL and testbench

//  Decode-stage issue controller for the 16-bit pipeline. Holds a scoreboard of in-flight

---
 rtl/hazard_pkg.sv | 32 +++
 rtl/hazard_match.sv | 33 +++
 rtl/hazard_ctl.sv | 129 ++++++++++++
 tb/tb_hazard_ctl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the decode-stage hazard controller: scoreboard entry,
// control-hazard FSM states and operand-forwarding select encodings.
package hazard_pkg;

  localparam int REG_W = 3;

  typedef struct packed {
    logic             v;
    logic             wr;
    logic             ld;
    logic [REG_W-1:0] dst;
  } sb_entry_t;

  localparam int SB_W = $bits(sb_entry_t);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BR_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  // Scoreboard slot 0 is EX, so the forward select is simply slot index + 1.
  function automatic logic [1:0] stage_to_fwd(input logic [1:0] stage);
    return 2'(stage + 2'd1);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one source register against every scoreboard entry and reports
// a hit, the youngest matching stage, and whether EX holds a matching load.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int PIPE_DEPTH = 3
) (
  input  logic [PIPE_DEPTH*SB_W-1:0] sb_i,
  input  logic [REG_W-1:0]           src_i,
  input  logic                       used_i,
  output logic                       hit_o,
  output logic [1:0]                 stage_o,
  output logic                       ld_hit_o
);

  sb_entry_t [PIPE_DEPTH-1:0] sb;
  assign sb = sb_i;

  // Walk from oldest to youngest so the youngest writer wins the select.
  always_comb begin
    hit_o   = 1'b0;
    stage_o = 2'd0;
    for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
      if (used_i && sb[i].v && sb[i].wr && (sb[i].dst == src_i)) begin
        hit_o   = 1'b1;
        stage_o = 2'(i);
      end
    end
  end

  assign ld_hit_o = used_i && sb[0].v && sb[0].wr && sb[0].ld && (sb[0].dst == src_i);

endmodule

// File: rtl/hazard_ctl.sv
// Decode-stage issue controller: RAW scoreboard stalls plus branch hold/flush
// sequencing. Define HAZARD_CTL_FORWARD_EN to stall only on load-use and forward the rest.
module hazard_ctl
  import hazard_pkg::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int BR_PENALTY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_rs_used,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic             id_reg_wr_en,
  input  logic             id_mem_read_en,
  input  logic             id_br_ju_en,
  input  logic             ex_br_resolve,
  input  logic             ex_br_taken,
  output logic             issue,
  output logic             stall,
  output logic             flush,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic             err
);

  localparam int CNT_W = (BR_PENALTY > 1) ? $clog2(BR_PENALTY) : 1;

  sb_entry_t [PIPE_DEPTH-1:0] sb_q, sb_d;
  state_t                     state_q;
  logic [CNT_W-1:0]           cnt_q;
  logic                       err_q;

  logic       aHit, bHit, aLdHit, bLdHit;
  logic [1:0] aStage, bStage;
  logic       dataHaz, stallInt, issueInt;
  logic [1:0] fwdA, fwdB;

  hazard_match #(.PIPE_DEPTH(PIPE_DEPTH)) u_match_a (
    .sb_i    (sb_q),
    .src_i   (id_rs),
    .used_i  (id_rs_used),
    .hit_o   (aHit),
    .stage_o (aStage),
    .ld_hit_o(aLdHit)
  );

  hazard_match #(.PIPE_DEPTH(PIPE_DEPTH)) u_match_b (
    .sb_i    (sb_q),
    .src_i   (id_rt),
    .used_i  (id_rt_used),
    .hit_o   (bHit),
    .stage_o (bStage),
    .ld_hit_o(bLdHit)
  );

`ifdef HAZARD_CTL_FORWARD_EN
  assign dataHaz = id_valid && (aLdHit || bLdHit);
  assign fwdA    = aHit ? stage_to_fwd(aStage) : FWD_RF;
  assign fwdB    = bHit ? stage_to_fwd(bStage) : FWD_RF;
`else
  logic unusedFwdInfo;
  assign unusedFwdInfo = ^{aStage, bStage, aLdHit, bLdHit};
  assign dataHaz = id_valid && (aHit || bHit);
  assign fwdA    = FWD_RF;
  assign fwdB    = FWD_RF;
`endif

  assign stallInt = id_valid && (dataHaz || (state_q != IDLE));
  assign issueInt = id_valid && !stallInt;

  assign issue     = !rst && issueInt;
  assign stall     = !rst && stallInt;
  assign flush     = !rst && (state_q == FLUSH);
  assign fwd_sel_a = rst ? FWD_RF : fwdA;
  assign fwd_sel_b = rst ? FWD_RF : fwdB;
  assign err       = err_q;

  // Issued instructions enter EX; a stall or empty decode inserts a bubble.
  always_comb begin
    sb_d = '0;
    if (issueInt) begin
      sb_d[0] = '{v: 1'b1, wr: id_reg_wr_en, ld: id_mem_read_en, dst: id_wr_reg};
    end
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      sb_d[i] = sb_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sb_q <= '0;
    else     sb_q <= sb_d;
  end

  // A resolve outside BR_WAIT is a protocol error; it never disturbs the sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= ex_br_resolve && (state_q != BR_WAIT);
      case (state_q)
        IDLE: begin
          if (issueInt && id_br_ju_en) state_q <= BR_WAIT;
        end
        BR_WAIT: begin
          if (ex_br_resolve) begin
            if (ex_br_taken) begin
              state_q <= FLUSH;
              cnt_q   <= CNT_W'(BR_PENALTY - 1);
            end else begin
              state_q <= IDLE;
            end
          end
        end
        FLUSH: begin
          if (cnt_q == '0) state_q <= IDLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctl.sv
// Scoreboard-driven bench for hazard_ctl; expectations follow HAZARD_CTL_FORWARD_EN
// when it is defined for the build.
module tb_hazard_ctl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [2:0] id_rs;
  logic       id_rs_used;
  logic [2:0] id_rt;
  logic       id_rt_used;
  logic [2:0] id_wr_reg;
  logic       id_reg_wr_en;
  logic       id_mem_read_en;
  logic       id_br_ju_en;
  logic       ex_br_resolve;
  logic       ex_br_taken;
  logic       issue;
  logic       stall;
  logic       flush;
  logic [1:0] fwd_sel_a;
  logic [1:0] fwd_sel_b;
  logic       err;

  hazard_ctl dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rs_used    (id_rs_used),
    .id_rt         (id_rt),
    .id_rt_used    (id_rt_used),
    .id_wr_reg     (id_wr_reg),
    .id_reg_wr_en  (id_reg_wr_en),
    .id_mem_read_en(id_mem_read_en),
    .id_br_ju_en   (id_br_ju_en),
    .ex_br_resolve (ex_br_resolve),
    .ex_br_taken   (ex_br_taken),
    .issue         (issue),
    .stall         (stall),
    .flush         (flush),
    .fwd_sel_a     (fwd_sel_a),
    .fwd_sel_b     (fwd_sel_b),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [2:0] rs;
    logic       rsU;
    logic [2:0] rt;
    logic       rtU;
    logic [2:0] wr;
    logic       wrEn;
    logic       ld;
    logic       br;
    logic       res;
    logic       tk;
    logic       rst;
  } stim_t;

  typedef struct packed {
    stim_t      s;
    logic [7:0] e;
  } cyc_t;

  logic [7:0] expQ[$];
  int checks = 0;
  int fails  = 0;

  function automatic stim_t sIdle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t sAlu(input logic [2:0] wr, input logic [2:0] rs, input logic rsU,
                                 input logic [2:0] rt, input logic rtU);
    stim_t s;
    s = '0;
    s.valid = 1'b1;
    s.wrEn  = 1'b1;
    s.wr    = wr;
    s.rs    = rs;
    s.rsU   = rsU;
    s.rt    = rt;
    s.rtU   = rtU;
    return s;
  endfunction

  function automatic stim_t sLoad(input logic [2:0] wr);
    stim_t s;
    s = sAlu(wr, 3'd0, 1'b0, 3'd0, 1'b0);
    s.ld = 1'b1;
    return s;
  endfunction

  function automatic stim_t sBr();
    stim_t s;
    s = '0;
    s.valid = 1'b1;
    s.br    = 1'b1;
    return s;
  endfunction

  function automatic stim_t sRes(input stim_t base, input logic tk);
    stim_t s;
    s = base;
    s.res = 1'b1;
    s.tk  = tk;
    return s;
  endfunction

  function automatic stim_t sRst(input stim_t base);
    stim_t s;
    s = base;
    s.rst = 1'b1;
    return s;
  endfunction

  // Packs {issue, stall, flush, fwd_sel_a, fwd_sel_b, err}.
  function automatic logic [7:0] ex(input logic iss, input logic stl, input logic fl,
                                    input logic [1:0] fa, input logic [1:0] fb, input logic er);
    return {iss, stl, fl, fa, fb, er};
  endfunction

  function automatic cyc_t cy(input stim_t s, input logic [7:0] e);
    cyc_t c;
    c.s = s;
    c.e = e;
    return c;
  endfunction

  task automatic applyStimulus(input stim_t s);
    rst            = s.rst;
    id_valid       = s.valid;
    id_rs          = s.rs;
    id_rs_used     = s.rsU;
    id_rt          = s.rt;
    id_rt_used     = s.rtU;
    id_wr_reg      = s.wr;
    id_reg_wr_en   = s.wrEn;
    id_mem_read_en = s.ld;
    id_br_ju_en    = s.br;
    ex_br_resolve  = s.res;
    ex_br_taken    = s.tk;
  endtask

  task automatic test_reset();
    cyc_t plan[$];
    logic [7:0] got, want;
    plan.push_back(cy(sRst(sAlu(3'd1, 3'd1, 1'b1, 3'd2, 1'b1)), ex(0, 0, 0, 2'd0, 2'd0, 0)));
    plan.push_back(cy(sIdle(), ex(0, 0, 0, 2'd0, 2'd0, 0)));
    plan.push_back(cy(sAlu(3'd1, 3'd2, 1'b1, 3'd3, 1'b1), ex(1, 0, 0, 2'd0, 2'd0, 0)));
    for (int k = 0; k < 3; k++) plan.push_back(cy(sIdle(), ex(0, 0, 0, 2'd0, 2'd0, 0)));
    foreach (plan[k]) begin
      applyStimulus(plan[k].s);
      expQ.push_back(plan[k].e);
      @(negedge clk);
      got  = {issue, stall, flush, fwd_sel_a, fwd_sel_b, err};
      want = expQ.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("[TB] FAIL reset cycle %0d: {iss,stl,fl,fa,fb,err} got %b required %b", k, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_raw_stall();
    cyc_t plan[$];
    logic [7:0] got, want;
    plan.push_back(cy(sAlu(3'd1, 3'd0, 1'b0, 3'd0, 1'b0), ex(1, 0, 0, 2'd0, 2'd0, 0)));
`ifdef HAZARD_CTL_FORWARD_EN
    plan.push_back(cy(sAlu(3'd2, 3'd1, 1'b1, 3'd0, 1'b0), ex(1, 0, 0, 2'd1, 2'd0, 0)));
    plan.push_back(cy(sAlu(3'd3, 3'd1, 1'b1, 3'd0, 1'b0), ex(1, 0, 0, 2'd2, 2'd0, 0)));
    plan.push_back(cy(sAlu(3'd4, 3'd1, 1'b1, 3'd2, 1'b1), ex(1, 0, 0, 2'd3, 2'd2, 0)));
`else
    for (int k = 0; k < 3; k++)
      plan.push_back(cy(sAlu(3'd2, 3'd1, 1'b1, 3'd0, 1'b0), ex(0, 1, 0, 2'd0, 2'd0, 0)));
    plan.push_back(cy(sAlu(3'd2, 3'd1, 1'b1, 3'd0, 1'b0), ex(1, 0, 0, 2'd0, 2'd0, 0)));
`endif
    for (int k = 0; k < 3; k++) plan.push_back(cy(sIdle(), ex(0, 0, 0, 2'd0, 2'd0, 0)));
    foreach (plan[k]) begin
      applyStimulus(plan[k].s);
      expQ.push_back(plan[k].e);
      @(negedge clk);
      got  = {issue, stall, flush, fwd_sel_a, fwd_sel_b, err};
      want = expQ.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("[TB] FAIL raw_stall cycle %0d: {iss,stl,fl,fa,fb,err} got %b required %b", k, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    cyc_t plan[$];
    logic [7:0] got, want;
    plan.push_back(cy(sLoad(3'd3), ex(1, 0, 0, 2'd0, 2'd0, 0)));
`ifdef HAZARD_CTL_FORWARD_EN
    plan.push_back(cy(sAlu(3'd4, 3'd0, 1'b0, 3'd3, 1'b1), ex(0, 1, 0, 2'd0, 2'd1, 0)));
    plan.push_back(cy(sAlu(3'd4, 3'd0, 1'b0, 3'd3, 1'b1), ex(1, 0, 0, 2'd0, 2'd2, 0)));
`else
    for (int k = 0; k < 3; k++)
      plan.push_back(cy(sAlu(3'd4, 3'd0, 1'b0, 3'd3, 1'b1), ex(0, 1, 0, 2'd0, 2'd0, 0)));
    plan.push_back(cy(sAlu(3'd4, 3'd0, 1'b0, 3'd3, 1'b1), ex(1, 0, 0, 2'd0, 2'd0, 0)));
`endif
    for (int k = 0; k < 3; k++) plan.push_back(cy(sIdle(), ex(0, 0, 0, 2'd0, 2'd0, 0)));
    foreach (plan[k]) begin
      applyStimulus(plan[k].s);
      expQ.push_back(plan[k].e);
      @(negedge clk);
      got  = {issue, stall, flush, fwd_sel_a, fwd_sel_b, err};
      want = expQ.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("[TB] FAIL load_use cycle %0d: {iss,stl,fl,fa,fb,err} got %b required %b", k, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_operand_used();
    cyc_t plan[$];
    logic [7:0] got, want;
    plan.push_back(cy(sAlu(3'd5, 3'd0, 1'b0, 3'd0, 1'b0), ex(1, 0, 0, 2'd0, 2'd0, 0)));
    plan.push_back(cy(sAlu(3'd6, 3'd5, 1'b0, 3'd5, 1'b0), ex(1, 0, 0, 2'd0, 2'd0, 0)));
`ifdef HAZARD_CTL_FORWARD_EN
    plan.push_back(cy(sAlu(3'd7, 3'd0, 1'b0, 3'd5, 1'b1), ex(1, 0, 0, 2'd0, 2'd2, 0)));
`else
    for (int k = 0; k < 2; k++)
      plan.push_back(cy(sAlu(3'd7, 3'd0, 1'b0, 3'd5, 1'b1), ex(0, 1, 0, 2'd0, 2'd0, 0)));
    plan.push_back(cy(sAlu(3'd7, 3'd0, 1'b0, 3'd5, 1'b1), ex(1, 0, 0, 2'd0, 2'd0, 0)));
`endif
    plan.push_back(cy(sAlu(3'd1, 3'd0, 1'b0, 3'd0, 1'b0), ex(1, 0, 0, 2'd0, 2'd0, 0)));
`ifdef HAZARD_CTL_FORWARD_EN
    plan.push_back(cy(sAlu(3'd0, 3'd0, 1'b0, 3'd0, 1'b0), ex(1, 0, 0, 2'd0, 2'd0, 0)));
    plan.push_back(cy(sAlu(3'd2, 3'd0, 1'b1, 3'd0, 1'b0), ex(1, 0, 0, 2'd1, 2'd0, 0)));
`else
    plan.push_back(cy(sAlu(3'd0, 3'd0, 1'b0, 3'd0, 1'b0), ex(1, 0, 0, 2'd0, 2'd0, 0)));
    plan.push_back(cy(sAlu(3'd2, 3'd0, 1'b1, 3'd0, 1'b0), ex(0, 1, 0, 2'd0, 2'd0, 0)));
`endif
    for (int k = 0; k < 3; k++) plan.push_back(cy(sIdle(), ex(0, 0, 0, 2'd0, 2'd0, 0)));
    foreach (plan[k]) begin
      applyStimulus(plan[k].s);
      expQ.push_back(plan[k].e);
      @(negedge clk);
      got  = {issue, stall, flush, fwd_sel_a, fwd_sel_b, err};
      want = expQ.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("[TB] FAIL operand_used cycle %0d: {iss,stl,fl,fa,fb,err} got %b required %b", k, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_taken();
    cyc_t plan[$];
    logic [7:0] got, want;
    plan.push_back(cy(sBr(), ex(1, 0, 0, 2'd0, 2'd0, 0)));
    plan.push_back(cy(sAlu(3'd5, 3'd0, 1'b0, 3'd0, 1'b0), ex(0, 1, 0, 2'd0, 2'd0, 0)));
    plan.push_back(cy(sRes(sAlu(3'd5, 3'd0, 1'b0, 3'd0, 1'b0), 1'b1), ex(0, 1, 0, 2'd0, 2'd0, 0)));
    plan.push_back(cy(sRes(sAlu(3'd5, 3'd0, 1'b0, 3'd0, 1'b0), 1'b1), ex(0, 1, 1, 2'd0, 2'd0, 0)));
    plan.push_back(cy(sIdle(), ex(0, 0, 1, 2'd0, 2'd0, 1)));
    plan.push_back(cy(sAlu(3'd5, 3'd0, 1'b0, 3'd0, 1'b0), ex(1, 0, 0, 2'd0, 2'd0, 0)));
    for (int k = 0; k < 3; k++) plan.push_back(cy(sIdle(), ex(0, 0, 0, 2'd0, 2'd0, 0)));
    foreach (plan[k]) begin
      applyStimulus(plan[k].s);
      expQ.push_back(plan[k].e);
      @(negedge clk);
      got  = {issue, stall, flush, fwd_sel_a, fwd_sel_b, err};
      want = expQ.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("[TB] FAIL branch_taken cycle %0d: {iss,stl,fl,fa,fb,err} got %b required %b", k, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_not_taken();
    cyc_t plan[$];
    logic [7:0] got, want;
    plan.push_back(cy(sBr(), ex(1, 0, 0, 2'd0, 2'd0, 0)));
    plan.push_back(cy(sRes(sAlu(3'd6, 3'd0, 1'b0, 3'd0, 1'b0), 1'b0), ex(0, 1, 0, 2'd0, 2'd0, 0)));
    plan.push_back(cy(sAlu(3'd6, 3'd0, 1'b0, 3'd0, 1'b0), ex(1, 0, 0, 2'd0, 2'd0, 0)));
    for (int k = 0; k < 3; k++) plan.push_back(cy(sIdle(), ex(0, 0, 0, 2'd0, 2'd0, 0)));
    foreach (plan[k]) begin
      applyStimulus(plan[k].s);
      expQ.push_back(plan[k].e);
      @(negedge clk);
      got  = {issue, stall, flush, fwd_sel_a, fwd_sel_b, err};
      want = expQ.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("[TB] FAIL branch_not_taken cycle %0d: {iss,stl,fl,fa,fb,err} got %b required %b", k, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_err_and_reset();
    cyc_t plan[$];
    logic [7:0] got, want;
    plan.push_back(cy(sRes(sIdle(), 1'b1), ex(0, 0, 0, 2'd0, 2'd0, 0)));
    plan.push_back(cy(sIdle(), ex(0, 0, 0, 2'd0, 2'd0, 1)));
    plan.push_back(cy(sIdle(), ex(0, 0, 0, 2'd0, 2'd0, 0)));
    plan.push_back(cy(sAlu(3'd4, 3'd0, 1'b0, 3'd0, 1'b0), ex(1, 0, 0, 2'd0, 2'd0, 0)));
    plan.push_back(cy(sBr(), ex(1, 0, 0, 2'd0, 2'd0, 0)));
    plan.push_back(cy(sRst(sAlu(3'd1, 3'd4, 1'b1, 3'd0, 1'b0)), ex(0, 0, 0, 2'd0, 2'd0, 0)));
    plan.push_back(cy(sAlu(3'd1, 3'd4, 1'b1, 3'd0, 1'b0), ex(1, 0, 0, 2'd0, 2'd0, 0)));
    for (int k = 0; k < 3; k++) plan.push_back(cy(sIdle(), ex(0, 0, 0, 2'd0, 2'd0, 0)));
    foreach (plan[k]) begin
      applyStimulus(plan[k].s);
      expQ.push_back(plan[k].e);
      @(negedge clk);
      got  = {issue, stall, flush, fwd_sel_a, fwd_sel_b, err};
      want = expQ.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("[TB] FAIL err_and_reset cycle %0d: {iss,stl,fl,fa,fb,err} got %b required %b", k, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    applyStimulus(sRst(sIdle()));
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_raw_stall();
    test_load_use();
    test_operand_used();
    test_branch_taken();
    test_branch_not_taken();
    test_err_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
